mem_access_ctrl: RTL and testbench

Initiator-side controller for the processor's word-addressed data memory. It takes load/store requests from the multi-cycle datapath using a valid/ready handshake. It converts byte addresses to word indices, checks alignment and range, and drives the memory's address, write-data, write-strobe and read-strobe lines. It then returns read data or a fault as a one-cycle response pulse. It sits between the datapath's MEM stage and the data memory block.

---
 rtl/mem_pkg.sv | 27 ++
 rtl/mem_access_ctrl_if.sv | 38 +++
 rtl/mem_access_ctrl.sv | 133 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access path: controller state
// encoding, byte-to-word shift and the alignment/range check that the
// instruction-fetch path reuses.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Memory is word addressed; byte address bits below this are the offset.
    localparam int WORD_SHIFT = 2;

    // Width the check works at, so one function serves any address width.
    localparam int CHK_W = 64;

    // True when the byte address is not word aligned or its word index is
    // beyond the end of memory. No wrap-around: any larger index faults.
    function automatic logic access_fault(input logic [CHK_W-1:0] byte_addr,
                                          input logic [CHK_W-1:0] num_words);
        return (byte_addr[WORD_SHIFT-1:0] != '0) ||
               ((byte_addr >> WORD_SHIFT) >= num_words);
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Bundle of the datapath request/response handshake and the data-memory bus.
//
// Handshake: a request transfers on the rising edge where req_valid and
// req_ready are both high. The requester keeps req_valid and the request
// fields steady until that edge. resp_valid is a single-cycle pulse with
// no back-pressure; resp_rdata/resp_fault are meaningful while it is high.
//
// master = requester plus memory side, slave = the controller.
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_fault;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_write_signal;
    logic              mem_read_signal;
    logic [DATA_W-1:0] mem_data_out;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, mem_data_out,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
               mem_addr, mem_data_in, mem_write_signal, mem_read_signal
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, mem_data_out,
        output req_ready, resp_valid, resp_rdata, resp_fault,
               mem_addr, mem_data_in, mem_write_signal, mem_read_signal
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Initiator-side data-memory controller: accepts one load/store at a time,
// checks alignment and range, strobes the word-addressed memory and returns
// a one-cycle response pulse. Every output comes straight from a register.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_WORDS = 1024,
    parameter int RD_WAIT   = 1
) (
    input  logic             clk,
    input  logic             reset,
    mem_access_ctrl_if.slave bus,
    output state_t           dbg_state
);

    // Counter only has to hold RD_WAIT-1.
    localparam int CNT_W = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic              valid_q, valid_d;
    logic              fault_q, fault_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wr_q, wr_d;
    logic              rd_q, rd_d;

    // State and all output registers; reset clears strobes immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            rdata_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
        end
    end

    // Next state and next register values; pulses default low, held data
    // defaults to its current value.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = 1'b0;
        valid_d = 1'b0;
        fault_d = 1'b0;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (bus.req_valid && ready_q) begin
                    ready_d = 1'b0;
                    if (access_fault(CHK_W'(bus.req_addr), CHK_W'(MEM_WORDS))) begin
                        // Fault skips the memory entirely.
                        state_d = RESP;
                        valid_d = 1'b1;
                        fault_d = 1'b1;
                        rdata_d = '0;
                    end else begin
                        addr_d = bus.req_addr >> WORD_SHIFT;
                        if (bus.req_write) begin
                            wdata_d = bus.req_wdata;
                            wr_d    = 1'b1;
                            state_d = WRITE;
                        end else begin
                            cnt_d   = RD_LOAD;
                            rd_d    = 1'b1;
                            state_d = READ;
                        end
                    end
                end
            end
            WRITE: begin
                state_d = RESP;
                valid_d = 1'b1;
            end
            READ: begin
                if (cnt_q == '0) begin
                    rdata_d = bus.mem_data_out;
                    valid_d = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    rd_d  = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    assign bus.req_ready        = ready_q;
    assign bus.resp_valid       = valid_q;
    assign bus.resp_fault       = fault_q;
    assign bus.resp_rdata       = rdata_q;
    assign bus.mem_addr         = addr_q;
    assign bus.mem_data_in      = wdata_q;
    assign bus.mem_write_signal = wr_q;
    assign bus.mem_read_signal  = rd_q;
    assign dbg_state            = state_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed steps followed by random requests,
// checked against a word-level reference memory and response rules.
module tb_mem_access_ctrl;
    import mem_pkg::*;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int MEM_WORDS = 1024;
    localparam int RD_WAIT   = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_access_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    state_t dbg_state;

    mem_access_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_WORDS(MEM_WORDS), .RD_WAIT(RD_WAIT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .dbg_state(dbg_state)
    );

    // Data memory: synchronous write, combinational read.
    logic [DATA_W-1:0] mem [0:MEM_WORDS-1];
    always @(posedge clk) begin
        if (bus.mem_write_signal)
            mem[bus.mem_addr[9:0]] <= bus.mem_data_in;
    end
    assign bus.mem_data_out = mem[bus.mem_addr[9:0]];

    // ---------------- scoreboard ----------------
    logic [DATA_W-1:0] ref_mem [0:MEM_WORDS-1];
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] exp_rdata;
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Compare the whole memory image against the reference.
    task automatic check_mem_image(input string tag);
        int diff;
        diff = 0;
        for (int i = 0; i < MEM_WORDS; i++)
            if (mem[i] !== ref_mem[i]) diff++;
        check(tag, 64'(diff), 64'd0);
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge in an idle cycle; returns at the falling edge
    // of the idle cycle after the response.
    task automatic do_req(input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit hold);
        logic        flt;
        logic [31:0] idx;
        logic [31:0] exp_d;
        int lat_exp, lat, n_wr, n_rd, n_both, n_badaddr;
        bit got;

        // Reference: outcome from the access rules alone.
        idx = addr >> 2;
        flt = (addr[1:0] != 2'b00) || (idx >= 32'(MEM_WORDS));
        if (flt) begin
            exp_rdata = '0;
            lat_exp = 1;
        end else if (wr) begin
            ref_mem[idx] = wdata;
            lat_exp = 2;
        end else begin
            exp_rdata = ref_mem[idx];
            lat_exp = RD_WAIT + 1;
        end
        exp_q.push_back(exp_rdata);

        check("ready_idle", 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        @(posedge clk);
        #1;
        if (!hold) bus.req_valid = 1'b0;

        got = 0; lat = 0; n_wr = 0; n_rd = 0; n_both = 0; n_badaddr = 0;
        for (int c = 1; c <= 12 && !got; c++) begin
            @(negedge clk);
            if (bus.mem_write_signal) n_wr++;
            if (bus.mem_read_signal) n_rd++;
            if (bus.mem_write_signal && bus.mem_read_signal) n_both++;
            if ((bus.mem_write_signal || bus.mem_read_signal) && bus.mem_addr !== idx)
                n_badaddr++;
            if (bus.mem_write_signal && bus.mem_data_in !== wdata) n_badaddr++;
            if (bus.resp_valid) begin
                got = 1;
                lat = c;
            end else if (bus.req_ready !== 1'b0) begin
                n_badaddr++;
            end
        end
        exp_d = exp_q.pop_front();
        check("resp_seen", 64'(got), 64'd1);
        check("latency", 64'(lat), 64'(lat_exp));
        check("resp_fault", 64'(bus.resp_fault), 64'(flt));
        check("resp_rdata", 64'(bus.resp_rdata), 64'(exp_d));
        check("wr_strobes", 64'(n_wr), 64'((!flt && wr) ? 1 : 0));
        check("rd_strobes", 64'(n_rd), 64'((!flt && !wr) ? RD_WAIT : 0));
        check("strobe_overlap", 64'(n_both), 64'd0);
        check("bus_during_access", 64'(n_badaddr), 64'd0);
        @(negedge clk);
        check("resp_pulse_end", 64'(bus.resp_valid), 64'd0);
    endtask

    // Hard time limit so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int act;
        logic [31:0] a;
        int r;

        reset = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        exp_rdata = '0;
        for (int i = 0; i < MEM_WORDS; i++) begin
            mem[i] = 32'(i);
            ref_mem[i] = 32'(i);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset values.
        check("rst_req_ready", 64'(bus.req_ready), 64'd1);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_resp_fault", 64'(bus.resp_fault), 64'd0);
        check("rst_resp_rdata", 64'(bus.resp_rdata), 64'd0);
        check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        check("rst_mem_data_in", 64'(bus.mem_data_in), 64'd0);
        check("rst_wr", 64'(bus.mem_write_signal), 64'd0);
        check("rst_rd", 64'(bus.mem_read_signal), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(IDLE));

        // Five quiet idle cycles.
        act = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.mem_write_signal || bus.mem_read_signal || bus.resp_valid || !bus.req_ready)
                act++;
        end
        check("idle_quiet", 64'(act), 64'd0);

        // Store then load back the same word.
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 0);
        check("mem_word4", 64'(mem[4]), 64'hDEADBEEF);
        do_req(1'b0, 32'h10, 32'h0, 0);

        // Load preloaded word, then a store leaves resp_rdata alone.
        do_req(1'b0, 32'h0C, 32'h0, 0);
        do_req(1'b1, 32'h20, 32'h12345678, 0);

        // Faults: misaligned, first out-of-range index, top of address space.
        do_req(1'b0, 32'h11, 32'h0, 0);
        do_req(1'b1, 32'h1000, 32'hCAFEF00D, 0);
        do_req(1'b1, 32'hFFFF_FFFC, 32'h55AA55AA, 0);
        check_mem_image("mem_after_faults");

        // Last valid word.
        do_req(1'b0, 32'hFFC, 32'h0, 0);
        do_req(1'b1, 32'hFFC, 32'hA5A5_0001, 0);
        do_req(1'b0, 32'hFFC, 32'h0, 0);

        // req_valid held through back-to-back loads.
        do_req(1'b0, 32'h14, 32'h0, 1);
        do_req(1'b0, 32'h18, 32'h0, 1);
        bus.req_valid = 1'b0;

        // Random mix over a small window plus misaligned / out-of-range.
        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            if (r < 6)
                a = 32'($urandom_range(0, 31)) << 2;
            else if (r < 8)
                a = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(1, 3));
            else
                a = 32'($urandom_range(1024, 65535)) << 2;
            do_req(1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)));
        end
        bus.req_valid = 1'b0;
        check_mem_image("mem_after_random");

        // Reset during READ: strobe drops at once, no response follows.
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 32'h8;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("rd_before_reset", 64'(bus.mem_read_signal), 64'd1);
        #1;
        reset = 1'b1;
        #1;
        check("rd_dropped_async", 64'(bus.mem_read_signal), 64'd0);
        check("ready_after_reset", 64'(bus.req_ready), 64'd1);
        check("rdata_after_reset", 64'(bus.resp_rdata), 64'd0);
        exp_rdata = '0;
        @(negedge clk);
        reset = 1'b0;
        act = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.resp_valid || bus.mem_read_signal || bus.mem_write_signal) act++;
        end
        check("no_resp_after_reset", 64'(act), 64'd0);
        check_mem_image("mem_after_reset");

        // Recovers normally.
        do_req(1'b0, 32'h8, 32'h0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
